// File: rtl/fixed_integer_mdv_sequencer_pkg.sv
// mdv_pkg: sequencer state encoding and size helpers shared by the MDV sequencer files
package mdv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, READY, FEED, WAIT, CAPT, DRAIN} state_t;
  function automatic int beats(input int width, input int mults);
    return width / mults;
  endfunction
  function automatic int nload(input int height, input int width, input int mults);
    return height * beats(width, mults);
  endfunction
endpackage

// File: rtl/fixed_integer_mdv_sequencer_if.sv
// fixed_integer_mdv_sequencer_if: valid/ready stream with a last marker
interface fixed_integer_mdv_sequencer_if #(parameter int W = 16);
  logic valid;
  logic ready;
  logic last;
  logic [W-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/fixed_integer_mdv_sequencer_result_buffer.sv
// mdv_result_buffer: HEIGHT-deep result store, filled by write index and replayed over valid/ready
module mdv_result_buffer
  import mdv_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int HEIGHT = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  output logic            wr_last,
  input  logic            rd_en,
  fixed_integer_mdv_sequencer_if.master m
);
  localparam int IW = $clog2(HEIGHT + 1);
  logic [BITS-1:0] mem [HEIGHT];
  logic [IW-1:0] wr_idx, rd_idx;
  assign wr_last = wr_idx == IW'(HEIGHT - 1);
  assign m.valid = rd_en;
  assign m.last  = rd_en && rd_idx == IW'(HEIGHT - 1);
  assign m.data  = rd_en ? mem[rd_idx] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) wr_idx <= wr_last ? '0 : wr_idx + IW'(1);
      if (m.valid && m.ready) rd_idx <= m.last ? '0 : rd_idx + IW'(1);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;
endmodule

// File: rtl/fixed_integer_mdv_sequencer.sv
// fixed_integer_mdv_sequencer: loads MDV weights from RAM, feeds one vector at a time, replays results
module fixed_integer_mdv_sequencer
  import mdv_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int WIDTH   = 40,
  parameter int HEIGHT  = 10,
  parameter int MULTS   = 2,
  parameter int TIMEOUT = 255,
  localparam int BEATS  = beats(WIDTH, MULTS),
  localparam int NLOAD  = nload(HEIGHT, WIDTH, MULTS),
  localparam int AW     = $clog2(NLOAD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_load,
  output logic                        load_done,
  output logic                        busy,
  output logic                        w_rd_en,
  output logic [AW-1:0]               w_addr,
  input  logic [MULTS-1:0][BITS-1:0]  w_data,
  fixed_integer_mdv_sequencer_if.slave  s,
  fixed_integer_mdv_sequencer_if.master m,
  output logic                        dp_load_matrix,
  output logic [MULTS-1:0][BITS-1:0]  dp_matrix_a_in,
  output logic                        dp_in_valid,
  output logic [MULTS-1:0][BITS-1:0]  dp_vector_b,
  input  logic                        dp_out_valid,
  input  logic [BITS-1:0]             dp_c,
  output logic                        err_timeout
);
  localparam int LW = $clog2(NLOAD + 1);
  localparam int BW = $clog2(BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [LW-1:0] ld_cnt;
  logic [BW-1:0] beat;
  logic [TW-1:0] tmr;
  logic loaded, accept, ld_end, feed_end, tmo, wr_en, wr_last;
  assign accept   = start_load && (state == IDLE || state == READY);
  // LOAD lingers one cycle past the last read so the delayed load strobe finishes before READY
  assign w_rd_en  = state == LOAD && ld_cnt < LW'(NLOAD);
  assign ld_end   = state == LOAD && ld_cnt == LW'(NLOAD);
  assign w_addr   = w_rd_en ? ld_cnt[AW-1:0] : '0;
  assign busy     = !(state == IDLE || state == READY);
  assign s.ready  = state == FEED;
  assign dp_in_valid    = s.valid && s.ready;
  assign dp_vector_b    = dp_in_valid ? s.data : '0;
  assign dp_matrix_a_in = dp_load_matrix ? w_data : '0;
  assign feed_end = dp_in_valid && beat == BW'(BEATS - 1);
  assign tmo      = state == WAIT && !dp_out_valid && tmr == TW'(TIMEOUT - 1);
  assign wr_en    = dp_out_valid && (state == WAIT || state == CAPT);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? LOAD : IDLE;
      LOAD:    nxt = ld_end ? READY : LOAD;
      READY:   nxt = accept ? LOAD : (s.valid && loaded) ? FEED : READY;
      FEED:    nxt = feed_end ? WAIT : FEED;
      WAIT:    nxt = wr_en ? (wr_last ? DRAIN : CAPT) : tmo ? READY : WAIT;
      CAPT:    nxt = (wr_en && wr_last) ? DRAIN : CAPT;
      DRAIN:   nxt = (m.valid && m.ready && m.last) ? READY : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      ld_cnt         <= '0;
      beat           <= '0;
      tmr            <= '0;
      loaded         <= 1'b0;
      load_done      <= 1'b0;
      dp_load_matrix <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= nxt;
      ld_cnt         <= state == LOAD ? ld_cnt + LW'(1) : '0;
      beat           <= dp_in_valid ? (feed_end ? '0 : beat + BW'(1)) : beat;
      tmr            <= state == WAIT ? tmr + TW'(1) : '0;
      loaded         <= loaded || ld_end;
      load_done      <= ld_end;
      dp_load_matrix <= w_rd_en;
      err_timeout    <= accept ? 1'b0 : (err_timeout || tmo);
    end
  mdv_result_buffer #(.BITS(BITS), .HEIGHT(HEIGHT)) u_buf (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(dp_c), .wr_last(wr_last),
    .rd_en(state == DRAIN), .m(m)
  );
  // MDV only produces results after a full vector, so anything else is an integration error
  a_stray_result: assert property (@(posedge clk) disable iff (rst)
    dp_out_valid |-> state inside {WAIT, CAPT});
endmodule
